dcache_dm: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate L1 data cache placed directly

---
 rtl/dcache_pkg.sv | 43 ++++
 rtl/dcache_lane_merge.sv | 35 +++
 rtl/dcache_dm.sv | 175 +++++++++++++++++
 tb/tb_dcache_dm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int DEF_SETS       = 64;
    localparam int DEF_LINE_WORDS = 4;
    localparam int OFF_W          = 2;
    localparam int WORD_W         = $clog2(DEF_LINE_WORDS);
    localparam int IDX_W          = $clog2(DEF_SETS);
    localparam int TAG_W          = 32 - IDX_W - WORD_W - OFF_W;

    localparam logic [1:0] WSZ_WORD   = 2'd0;
    localparam logic [1:0] WSZ_BYTE   = 2'd1;
    localparam logic [1:0] WSZ_HALF   = 2'd2;
    localparam logic [1:0] WSZ_TRIPLE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESUME = 2'd3
    } dcache_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return (size == WSZ_WORD) ? 3'd4 : {1'b0, size};
    endfunction

    // Strobe bit 3 is lane 0 (bits [31:24]); bytes running past lane 3 are dropped.
    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] strb;
        int         nb;
        strb = '0;
        nb   = int'(size_bytes(size));
        if (size == WSZ_WORD) begin
            strb = 4'b1111;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (l >= int'(offset) && l < int'(offset) + nb) strb[3-l] = 1'b1;
            end
        end
        return strb;
    endfunction

endpackage

// File: rtl/dcache_lane_merge.sv
// Places right-justified store data onto big-endian byte lanes and merges it
// into an existing cached word.
module dcache_lane_merge
    import dcache_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] data_i,
    input  logic [31:0] old_word_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] merged_o
);

    logic [3:0] strb;
    int         nb;

    always_comb begin
        strb     = lane_strobe(size_i, offset_i);
        nb       = int'(size_bytes(size_i));
        wdata_o  = '0;
        merged_o = old_word_i;
        for (int l = 0; l < 4; l++) begin
            if (size_i == WSZ_WORD) begin
                wdata_o[31-8*l -: 8] = data_i[31-8*l -: 8];
            end else if (strb[3-l]) begin
                // First byte of the store (most significant of N) lands on lane offset.
                wdata_o[31-8*l -: 8] = data_i[8*(nb-1-(l-int'(offset_i))) +: 8];
            end
            if (strb[3-l]) merged_o[31-8*l -: 8] = wdata_o[31-8*l -: 8];
        end
        wstrb_o = strb;
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a
// single-word req/ack memory port.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   addr_IN,
    input  logic [31:0]   data_write_IN,
    input  logic [1:0]    write_size_IN,
    input  logic          MemRead_IN,
    input  logic          MemWrite_IN,
    output logic [31:0]   data_read_OUT,
    output logic          stall_OUT,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output dcache_state_e state_dbg_o
);

    localparam int W_W = $clog2(LINE_WORDS);
    localparam int I_W = $clog2(SETS);
    localparam int T_W = 32 - I_W - W_W - 2;

    logic [T_W-1:0] tag;
    logic [I_W-1:0] idx;
    logic [W_W-1:0] word;

    assign word = addr_IN[2 +: W_W];
    assign idx  = addr_IN[2+W_W +: I_W];
    assign tag  = addr_IN[31 -: T_W];

    logic [T_W-1:0]  tag_q  [SETS];
    logic [31:0]     data_q [SETS][LINE_WORDS];
    logic [SETS-1:0] valid_q;

    dcache_state_e state_q, state_d;
    logic [W_W-1:0] cnt_q, cnt_d;
    logic           req_q, req_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     wstrb_q, wstrb_d;

    logic        hit;
    logic [31:0] cur_word;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] merged;
    logic        refill_ack;
    logic        write_ack;
    logic        last_word;

    assign hit        = valid_q[idx] && (tag_q[idx] == tag);
    assign cur_word   = data_q[idx][word];
    assign refill_ack = (state_q == ST_REFILL) && mem_ack;
    assign write_ack  = (state_q == ST_WRITE) && mem_ack;
    assign last_word  = (cnt_q == {W_W{1'b1}});

    dcache_lane_merge u_merge (
        .size_i     (write_size_IN),
        .offset_i   (addr_IN[1:0]),
        .data_i     (data_write_IN),
        .old_word_i (cur_word),
        .wstrb_o    (st_wstrb),
        .wdata_o    (st_wdata),
        .merged_o   (merged)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        stall_OUT = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (MemWrite_IN) begin
                    stall_OUT = 1'b1;
                    state_d   = ST_WRITE;
                    req_d     = 1'b1;
                    we_d      = 1'b1;
                    addr_d    = {addr_IN[31:2], 2'b00};
                    wdata_d   = st_wdata;
                    wstrb_d   = st_wstrb;
                end else if (MemRead_IN && !hit) begin
                    stall_OUT = 1'b1;
                    state_d   = ST_REFILL;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    we_d      = 1'b0;
                    addr_d    = {tag, idx, {W_W{1'b0}}, 2'b00};
                    wdata_d   = '0;
                    wstrb_d   = '0;
                end
            end
            ST_REFILL: begin
                stall_OUT = 1'b1;
                if (mem_ack) begin
                    if (last_word) begin
                        state_d = ST_RESUME;
                        cnt_d   = '0;
                        req_d   = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        addr_d = {tag, idx, cnt_q + 1'b1, 2'b00};
                    end
                end
            end
            ST_WRITE: begin
                stall_OUT = 1'b1;
                if (mem_ack) begin
                    state_d = ST_RESUME;
                    req_d   = 1'b0;
                end
            end
            ST_RESUME: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            if (refill_ack && last_word) valid_q[idx] <= 1'b1;
        end
    end

    // Tag/data storage has no reset; only the valid bits matter after reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (refill_ack) begin
                data_q[idx][cnt_q] <= mem_rdata;
                if (last_word) tag_q[idx] <= tag;
            end
            if (write_ack && hit) data_q[idx][word] <= merged;
        end
    end

    assign data_read_OUT = hit ? cur_word : 32'h0;
    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_dcache_dm.sv
// Directed, table-driven bench for dcache_dm with a word-addressed memory model.
module tb_dcache_dm;
    import dcache_pkg::*;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   addr_IN;
    logic [31:0]   data_write_IN;
    logic [1:0]    write_size_IN;
    logic          MemRead_IN;
    logic          MemWrite_IN;
    logic [31:0]   data_read_OUT;
    logic          stall_OUT;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    dcache_state_e state_dbg;

    dcache_dm dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .addr_IN       (addr_IN),
        .data_write_IN (data_write_IN),
        .write_size_IN (write_size_IN),
        .MemRead_IN    (MemRead_IN),
        .MemWrite_IN   (MemWrite_IN),
        .data_read_OUT (data_read_OUT),
        .stall_OUT     (stall_OUT),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .state_dbg_o   (state_dbg)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_m [logic [31:0]];

    // op: 0 = no request, 1 = load, 2 = store, 3 = store with load also high
    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        int          delay;
        int          nreads;
        logic [3:0]  wstrb;
        logic [31:0] lane_data;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[20];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_access(input vec_t v, input int id);
        int       waited;
        int       reads;
        int       writes;
        bit       have_snap;
        bit       done;
        logic [68:0] snap;
        logic [31:0] m;
        exp_q.delete();
        for (int k = 0; k < v.nreads; k++) exp_q.push_back((v.addr & 32'hFFFF_FFF0) + 32'(k * 4));
        if (v.op >= 2) exp_q.push_back(v.addr & 32'hFFFF_FFFC);
        addr_IN       = v.addr;
        data_write_IN = v.wdata;
        write_size_IN = v.size;
        MemRead_IN    = (v.op == 1 || v.op == 3);
        MemWrite_IN   = (v.op >= 2);
        waited = 0; reads = 0; writes = 0; have_snap = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge CLK);
            if (c == 0)
                check($sformatf("v%0d first stall", id), {31'b0, stall_OUT}, 32'(v.nreads > 0 || v.op >= 2));
            if (!stall_OUT) begin
                check($sformatf("v%0d rdata", id), data_read_OUT, v.rdata);
                check($sformatf("v%0d req idle", id), {31'b0, mem_req}, 32'h0);
                check($sformatf("v%0d reads", id), 32'(reads), 32'(v.nreads));
                check($sformatf("v%0d writes", id), 32'(writes), 32'(v.op >= 2));
                done = 1;
            end else if (mem_req) begin
                if (have_snap)
                    check($sformatf("v%0d held stable", id), 32'({mem_we, mem_wstrb, mem_addr, mem_wdata} != snap), 32'h0);
                snap = {mem_we, mem_wstrb, mem_addr, mem_wdata};
                have_snap = 1;
                if (waited == v.delay) begin
                    if (exp_q.size() > 0) check($sformatf("v%0d addr", id), mem_addr, exp_q.pop_front());
                    check($sformatf("v%0d we", id), {31'b0, mem_we}, 32'(v.op >= 2));
                    if (mem_we) begin
                        writes++;
                        check($sformatf("v%0d wstrb", id), {28'b0, mem_wstrb}, {28'b0, v.wstrb});
                        m = strb_mask(mem_wstrb);
                        check($sformatf("v%0d wdata", id), mem_wdata & m, v.lane_data);
                        mem_m[mem_addr] = (mem_rd(mem_addr) & ~m) | (mem_wdata & m);
                    end else begin
                        reads++;
                        mem_rdata = mem_rd(mem_addr);
                    end
                    mem_ack = 1'b1;
                    waited = 0;
                    have_snap = 0;
                    @(posedge CLK);
                    #1 mem_ack = 1'b0;
                end else begin
                    waited++;
                end
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL v%0d timeout: stall still %b expected 0", id, stall_OUT);
        end
        @(posedge CLK);
        #1;
        MemRead_IN  = 1'b0;
        MemWrite_IN = 1'b0;
    endtask

    initial begin
        int acks;
        vecs[0]  = '{1, 32'h1000, 32'h0,        2'd0, 0, 4, 4'b0000, 32'h0,        32'hC0DE1000};
        vecs[1]  = '{1, 32'h1000, 32'h0,        2'd0, 0, 0, 4'b0000, 32'h0,        32'hC0DE1000};
        vecs[2]  = '{1, 32'h1008, 32'h0,        2'd0, 0, 0, 4'b0000, 32'h0,        32'hC0DE1008};
        vecs[3]  = '{2, 32'h1001, 32'hAB,       2'd1, 0, 0, 4'b0100, 32'h00AB0000, 32'hC0AB1000};
        vecs[4]  = '{1, 32'h1000, 32'h0,        2'd0, 0, 0, 4'b0000, 32'h0,        32'hC0AB1000};
        vecs[5]  = '{2, 32'h100E, 32'hBEEF,     2'd2, 0, 0, 4'b0011, 32'h0000BEEF, 32'hC0DEBEEF};
        vecs[6]  = '{1, 32'h100C, 32'h0,        2'd0, 0, 0, 4'b0000, 32'h0,        32'hC0DEBEEF};
        vecs[7]  = '{2, 32'h1005, 32'h123456,   2'd3, 0, 0, 4'b0111, 32'h00123456, 32'hC0123456};
        vecs[8]  = '{2, 32'h1006, 32'hAABBCC,   2'd3, 0, 0, 4'b0011, 32'h0000AABB, 32'hC012AABB};
        vecs[9]  = '{1, 32'h1004, 32'h0,        2'd0, 0, 0, 4'b0000, 32'h0,        32'hC012AABB};
        vecs[10] = '{2, 32'h2000, 32'hDEADBEEF, 2'd0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[11] = '{1, 32'h2000, 32'h0,        2'd0, 0, 4, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[12] = '{1, 32'h1000, 32'h0,        2'd0, 0, 4, 4'b0000, 32'h0,        32'hC0AB1000};
        vecs[13] = '{1, 32'h1400, 32'h0,        2'd0, 0, 4, 4'b0000, 32'h0,        32'hC0DE1400};
        vecs[14] = '{1, 32'h1000, 32'h0,        2'd0, 5, 4, 4'b0000, 32'h0,        32'hC0AB1000};
        vecs[15] = '{2, 32'h1010, 32'h11223344, 2'd0, 3, 0, 4'b1111, 32'h11223344, 32'h0};
        vecs[16] = '{0, 32'h1008, 32'h0,        2'd0, 0, 0, 4'b0000, 32'h0,        32'hC0DE1008};
        vecs[17] = '{2, 32'h1002, 32'h01020304, 2'd0, 0, 0, 4'b1111, 32'h01020304, 32'h01020304};
        vecs[18] = '{3, 32'h1003, 32'h55,       2'd1, 0, 0, 4'b0001, 32'h00000055, 32'h01020355};
        vecs[19] = '{1, 32'h1010, 32'h0,        2'd0, 0, 4, 4'b0000, 32'h0,        32'h11223344};

        RESET = 1'b1; addr_IN = 32'h1000; data_write_IN = '0; write_size_IN = '0;
        MemRead_IN = 1'b0; MemWrite_IN = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        @(negedge CLK);
        check("reset stall", {31'b0, stall_OUT}, 32'h0);
        check("reset req", {31'b0, mem_req}, 32'h0);
        check("reset we", {31'b0, mem_we}, 32'h0);
        check("reset addr", mem_addr, 32'h0);
        check("reset wdata", mem_wdata, 32'h0);
        check("reset wstrb", {28'b0, mem_wstrb}, 32'h0);
        check("reset rdata", data_read_OUT, 32'h0);
        check("reset state", 32'(state_dbg), 32'(ST_IDLE));
        @(posedge CLK);
        #1;

        for (int i = 0; i < 20; i++) do_access(vecs[i], i);

        // Reset in the middle of a refill, after the second word returns.
        addr_IN = 32'h3000; MemRead_IN = 1'b1; acks = 0;
        for (int c = 0; c < 50 && acks < 2; c++) begin
            @(negedge CLK);
            if (mem_req) begin
                mem_rdata = mem_rd(mem_addr);
                mem_ack = 1'b1;
                acks++;
                @(posedge CLK);
                #1 mem_ack = 1'b0;
            end
        end
        check("midfill acks", 32'(acks), 32'd2);
        RESET = 1'b1; MemRead_IN = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("post reset req", {31'b0, mem_req}, 32'h0);
        check("post reset state", 32'(state_dbg), 32'(ST_IDLE));
        check("post reset stall", {31'b0, stall_OUT}, 32'h0);
        check("post reset rdata", data_read_OUT, 32'h0);
        @(posedge CLK);
        #1;
        do_access('{1, 32'h1000, 32'h0, 2'd0, 0, 4, 4'b0000, 32'h0, 32'h01020355}, 20);
        do_access('{1, 32'h3004, 32'h0, 2'd0, 0, 4, 4'b0000, 32'h0, 32'hC0DE3004}, 21);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
